uio_nibble_sender: RTL

//  Initiator side of the 4-bit uio handshake link: takes bytes from the core (e.g. the ui_in+uio_in sum)
//  and sends each as two nibbles (high first) on uio[3:0] with a 4-phase strobe/ack handshake.

---
 rtl/uio_link_pkg.sv | 30 +++
 rtl/uio_sync.sv | 28 ++
 rtl/uio_nibble_sender.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uio_link_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uio_link_pkg: shared definitions for both ends of the 4-bit uio strobe/ack link.
// Rev 1.0
// ----------------------------------------------------------------------------
package uio_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_HI = 3'd1,
    ST_STB_HI   = 3'd2,
    ST_REL_HI   = 3'd3,
    ST_SETUP_LO = 3'd4,
    ST_STB_LO   = 3'd5,
    ST_REL_LO   = 3'd6
  } uio_state_t;

  localparam int ACK_BIT = 5;
  localparam int STB_BIT = 4;
  localparam int NIB_LSB = 0;
  localparam logic [7:0] UIO_OE_SENDER = 8'h1F;

  // States in which the link waits on the remote ack and the timeout runs.
  function automatic logic is_wait_state(input uio_state_t s);
    return (s == ST_STB_HI) || (s == ST_REL_HI) ||
           (s == ST_STB_LO) || (s == ST_REL_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uio_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uio_sync: STAGES-deep single-bit synchronizer, flops cleared by reset.
// Rev 1.0
// ----------------------------------------------------------------------------
module uio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uio_nibble_sender.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uio_nibble_sender: sends each byte as two nibbles (high first) over uio[3:0]
// using a 4-phase strobe/ack handshake with per-phase timeout.  Rev 1.0
// ----------------------------------------------------------------------------
module uio_nibble_sender
  import uio_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [TIMEOUT_W-1:0] c_timeout = TIMEOUT_W'(TIMEOUT_CYCLES);

  uio_state_t           r_state;
  uio_state_t           w_state_next;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [7:0]           r_byte;
  logic [7:0]           r_uio_out;
  logic [7:0]           r_uio_oe;
  logic                 r_in_ready;
  logic                 r_timeout_err;
  logic                 w_ack_s;
  logic                 w_accept;
  logic                 w_expired;
  logic                 w_timeout;
  logic [3:0]           w_nib_next;
  logic [7:0]           w_uio_out_next;
  logic                 w_unused_uio;

  // Only the ack line is an input on this side of the link.
  assign w_unused_uio = ^(uio_in & ~(8'd1 << ACK_BIT));

  uio_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (uio_in[ACK_BIT]),
    .q   (w_ack_s)
  );

  // r_in_ready is only ever set while the FSM sits in IDLE.
  assign w_accept  = in_valid && r_in_ready;
  assign w_expired = (r_cnt == c_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ack is tested before expiry so an ack on the last cycle still wins.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_accept) w_state_next = ST_SETUP_HI;
      ST_SETUP_HI: w_state_next = ST_STB_HI;
      ST_STB_HI: begin
        if (w_ack_s)        w_state_next = ST_REL_HI;
        else if (w_expired) begin w_state_next = ST_IDLE; w_timeout = 1'b1; end
      end
      ST_REL_HI: begin
        if (!w_ack_s)       w_state_next = ST_SETUP_LO;
        else if (w_expired) begin w_state_next = ST_IDLE; w_timeout = 1'b1; end
      end
      ST_SETUP_LO: w_state_next = ST_STB_LO;
      ST_STB_LO: begin
        if (w_ack_s)        w_state_next = ST_REL_LO;
        else if (w_expired) begin w_state_next = ST_IDLE; w_timeout = 1'b1; end
      end
      ST_REL_LO: begin
        if (!w_ack_s)       w_state_next = ST_IDLE;
        else if (w_expired) begin w_state_next = ST_IDLE; w_timeout = 1'b1; end
      end
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with r_state.
  always_comb begin
    w_nib_next     = 4'h0;
    w_uio_out_next = 8'h00;
    case (w_state_next)
      ST_SETUP_HI, ST_STB_HI, ST_REL_HI: w_nib_next = w_accept ? in_data[7:4] : r_byte[7:4];
      ST_SETUP_LO, ST_STB_LO, ST_REL_LO: w_nib_next = r_byte[3:0];
      default:                           w_nib_next = 4'h0;
    endcase
    w_uio_out_next[NIB_LSB +: 4] = w_nib_next;
    w_uio_out_next[STB_BIT]      = (w_state_next == ST_STB_HI) || (w_state_next == ST_STB_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte        <= 8'h00;
      r_cnt         <= '0;
      r_uio_out     <= 8'h00;
      r_uio_oe      <= 8'h00;
      r_in_ready    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_byte <= in_data;
      end
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (is_wait_state(r_state)) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      r_uio_out     <= w_uio_out_next;
      r_uio_oe      <= UIO_OE_SENDER;
      r_in_ready    <= (w_state_next == ST_IDLE);
      r_timeout_err <= w_timeout;
    end
  end

  assign uio_out     = r_uio_out;
  assign uio_oe      = r_uio_oe;
  assign in_ready    = r_in_ready;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
